// File: rtl/bomb_keypad_defuser.sv
// 4x4 active-low keypad scanner with frame debounce and a 4-digit defuse-code checker.
// Reports defused / wrong / lockout status and honours the fuse fail flag.
module bomb_keypad_defuser #(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned DEBOUNCE  = 2,
    parameter logic [15:0] CODE      = 16'h1234,
    parameter int unsigned MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fail_in,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [2:0] digits,
    output logic       wrong,
    output logic [2:0] tries,
    output logic       defused,
    output logic       locked
);
    localparam int unsigned    DivW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]     DebTarget = 4'(DEBOUNCE);
    localparam logic [2:0]     TriesMax  = 3'(MAX_TRIES);

    typedef enum logic [2:0] {StIdle, StEnter, StCheck, StDefused, StLocked} state_e;

    logic [DivW-1:0] div_q;
    logic [1:0]      col_idx_q;
    logic [1:0]      lows_q;      // 0, 1 or 2 (= more than one) low bits this frame
    logic [3:0]      key_q;
    logic [4:0]      prev_q;      // {is_key, code}; NONE and MULTI both encode as 0
    logic [3:0]      stable_q;
    logic            armed_q;
    logic            key_valid_q;
    logic [3:0]      key_code_q;

    logic       dwell_end;
    logic [2:0] row_lows;
    logic [1:0] row_idx;
    logic [1:0] sample_lows;
    logic [2:0] lows_sum;
    logic [1:0] frame_lows;
    logic [3:0] frame_key;
    logic [4:0] frame_res;
    logic [3:0] stable_nxt;

    state_e      state_q, state_d;
    logic [2:0]  digits_q, digits_d;
    logic [2:0]  tries_q, tries_d;
    logic [15:0] buf_q, buf_d;
    logic        wrong_c;

    assign dwell_end = (div_q == DivLast);
    assign col       = ~(4'b0001 << col_idx_q);

    always_comb begin
        row_lows = 3'd0;
        row_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!row[i]) begin
                row_lows = row_lows + 3'd1;
                row_idx  = i[1:0];
            end
        end
        sample_lows = (row_lows > 3'd1) ? 2'd2 : row_lows[1:0];
        lows_sum    = {1'b0, lows_q} + {1'b0, sample_lows};
        frame_lows  = (lows_sum > 3'd1) ? 2'd2 : lows_sum[1:0];
        frame_key   = (row_lows == 3'd1) ? {col_idx_q, row_idx} : key_q;
        frame_res   = (frame_lows == 2'd1) ? {1'b1, frame_key} : 5'd0;
        if (frame_res == prev_q) begin
            stable_nxt = (stable_q >= DebTarget) ? DebTarget : stable_q + 4'd1;
        end else begin
            stable_nxt = 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            lows_q      <= 2'd0;
            key_q       <= 4'd0;
            prev_q      <= 5'd0;
            stable_q    <= 4'd0;
            armed_q     <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_valid_q <= 1'b0;
            if (dwell_end) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                if (row_lows == 3'd1) begin
                    key_q <= {col_idx_q, row_idx};
                end
                if (col_idx_q == 2'd3) begin
                    lows_q   <= 2'd0;
                    prev_q   <= frame_res;
                    stable_q <= stable_nxt;
                    // A key fires once, then must see a stable release before firing again
                    if (stable_nxt == DebTarget) begin
                        if (frame_res[4]) begin
                            if (armed_q) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= frame_res[3:0];
                                armed_q     <= 1'b0;
                            end
                        end else begin
                            armed_q <= 1'b1;
                        end
                    end
                end else begin
                    lows_q <= frame_lows;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        tries_d  = tries_q;
        buf_d    = buf_q;
        wrong_c  = 1'b0;
        unique case (state_q)
            StIdle: begin
                digits_d = 3'd0;
                tries_d  = 3'd0;
                buf_d    = 16'd0;
                if (start) state_d = StEnter;
            end
            StEnter: begin
                if (fail_in) begin
                    state_d = StLocked;
                end else if (!start) begin
                    state_d  = StIdle;
                    digits_d = 3'd0;
                    tries_d  = 3'd0;
                    buf_d    = 16'd0;
                end else if (key_valid_q) begin
                    if (key_code_q == 4'hF) begin
                        digits_d = 3'd0;
                    end else begin
                        buf_d    = {buf_q[11:0], key_code_q};
                        digits_d = digits_q + 3'd1;
                        if (digits_q == 3'd3) state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (fail_in) begin
                    state_d = StLocked;
                end else if (!start) begin
                    state_d  = StIdle;
                    digits_d = 3'd0;
                    tries_d  = 3'd0;
                    buf_d    = 16'd0;
                end else if (buf_q == CODE) begin
                    state_d = StDefused;
                end else begin
                    wrong_c  = 1'b1;
                    tries_d  = tries_q + 3'd1;
                    digits_d = 3'd0;
                    state_d  = (tries_q + 3'd1 == TriesMax) ? StLocked : StEnter;
                end
            end
            StDefused: state_d = StDefused;
            StLocked:  state_d = StLocked;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            digits_q <= 3'd0;
            tries_q  <= 3'd0;
            buf_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            tries_q  <= tries_d;
            buf_q    <= buf_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digits    = digits_q;
    assign tries     = tries_q;
    assign wrong     = wrong_c;
    assign defused   = (state_q == StDefused);
    assign locked    = (state_q == StLocked);

endmodule

// File: tb/tb_bomb_keypad_defuser.sv
// Bench for bomb_keypad_defuser: a keypad model drives rows from the column scan,
// and a digit-queue model of the game predicts every status output.
module tb_bomb_keypad_defuser;
    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned DEBOUNCE  = 2;
    localparam logic [15:0] CODE      = 16'h1234;
    localparam int unsigned MAX_TRIES = 3;
    localparam int          Frame     = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       fail_in;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] digits;
    logic       wrong;
    logic [2:0] tries;
    logic       defused;
    logic       locked;

    logic [15:0] pressed;  // bit col*4+row = key held down

    int total = 0;
    int bad   = 0;

    logic [3:0] m_entry[$];
    int         m_tries;
    bit         m_def;
    bit         m_lock;
    bit         m_start;

    bomb_keypad_defuser #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE),
        .CODE     (CODE),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .fail_in  (fail_in),
        .row      (row),
        .col      (col),
        .key_valid(key_valid),
        .key_code (key_code),
        .digits   (digits),
        .wrong    (wrong),
        .tries    (tries),
        .defused  (defused),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    // Passive keypad: a held key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4+r]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_key(input logic [3:0] k, input bit f);
        logic [15:0] v;
        if (!m_start || m_def || m_lock) return 0;
        if (f) begin
            m_lock = 1'b1;
            return 0;
        end
        if (k == 4'hF) begin
            m_entry.delete();
            return 0;
        end
        m_entry.push_back(k);
        if (m_entry.size() < 4) return 0;
        v = {m_entry[0], m_entry[1], m_entry[2], m_entry[3]};
        if (v == CODE) begin
            m_def = 1'b1;
            return 0;
        end
        m_entry.delete();
        m_tries++;
        if (m_tries == int'(MAX_TRIES)) m_lock = 1'b1;
        return 1;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, ".digits"}, 32'(digits), 32'(m_entry.size()));
        chk({tag, ".tries"}, 32'(tries), 32'(m_tries));
        chk({tag, ".defused"}, 32'(defused), 32'(m_def));
        chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
    endtask

    // Leaves the bench #1 after the edge that starts a new frame (col back to 1110)
    task automatic align();
        logic [3:0] last;
        bit found;
        last  = col;
        found = 1'b0;
        for (int i = 0; i < 2 * Frame && !found; i++) begin
            @(posedge clk);
            #1;
            if (col == 4'b1110 && last == 4'b0111) found = 1'b1;
            last = col;
        end
        chk("align", 32'(found), 32'd1);
    endtask

    // Hold k for 3 frames, release for 3; optionally raise fail_in as the key is accepted
    task automatic press(input logic [3:0] k, input bit with_fail);
        int pulses, at, wrongs, exp_wrong;
        logic [3:0] seen;
        pulses = 0;
        at     = -1;
        wrongs = 0;
        seen   = 4'h0;
        align();
        pressed    = 16'h0;
        pressed[k] = 1'b1;
        for (int n = 1; n <= 6 * Frame; n++) begin
            @(posedge clk);
            #1;
            if (n == 3 * Frame) pressed = 16'h0;
            if (key_valid) begin
                pulses++;
                at   = n;
                seen = key_code;
                if (with_fail) fail_in = 1'b1;
            end
            if (wrong) wrongs++;
        end
        exp_wrong = model_key(k, with_fail);
        chk("key.pulses", 32'(pulses), 32'd1);
        chk("key.latency", 32'(at), 32'(DEBOUNCE * Frame));
        chk("key.code", 32'(seen), 32'(k));
        chk("key.wrong", 32'(wrongs), 32'(exp_wrong));
        check_status("key");
    endtask

    task automatic enter_code(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] d;
            d = v[15-4*i -: 4];
            press(d, 1'b0);
        end
    endtask

    task automatic idle_frames(input int n);
        pressed = 16'h0;
        repeat (n * Frame) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst.col", 32'(col), 32'h0000000E);
        chk("rst.key_valid", 32'(key_valid), 32'd0);
        chk("rst.key_code", 32'(key_code), 32'd0);
        chk("rst.wrong", 32'(wrong), 32'd0);
        m_entry.delete();
        m_tries = 0;
        m_def   = 1'b0;
        m_lock  = 1'b0;
        check_status("rst");
        pressed = 16'h0;
        fail_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_frames(3);
    endtask

    initial begin
        logic [15:0] v;
        logic [3:0]  a, b;
        int          pulses;

        rst     = 1'b1;
        start   = 1'b0;
        fail_in = 1'b0;
        pressed = 16'h0;
        m_tries = 0;
        m_def   = 1'b0;
        m_lock  = 1'b0;
        m_start = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.col", 32'(col), 32'h0000000E);
        chk("reset.key_code", 32'(key_code), 32'd0);
        check_status("reset");

        // Column sweep with no keys
        @(negedge clk);
        rst = 1'b0;
        chk("sweep.col0", 32'(col), 32'h0000000E);
        pulses = 0;
        for (int m = 1; m <= 2 * Frame; m++) begin
            logic [3:0] e;
            @(posedge clk);
            #1;
            e = ~(4'b0001 << ((m / SCAN_DIV) % 4));
            chk("sweep.col", 32'(col), 32'(e));
            if (key_valid) pulses++;
        end
        chk("sweep.pulses", 32'(pulses), 32'd0);
        check_status("sweep");

        // Single press while idle: pulse fires, entry ignored
        press(4'h6, 1'b0);

        // Armed game: random partial entries cleared by F, then the right code
        start   = 1'b1;
        m_start = 1'b1;
        for (int t = 0; t < 2; t++) begin
            int len;
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) press(4'($urandom_range(0, 14)), 1'b0);
            press(4'hF, 1'b0);
        end
        enter_code(CODE);
        fail_in = 1'b1;
        press(4'($urandom_range(0, 15)), 1'b0);
        fail_in = 1'b0;
        check_status("defused.sticky");

        // Multi-key, wrong codes to lockout, then the right code must not defuse
        pulse_reset();
        a = 4'($urandom_range(0, 15));
        do b = 4'($urandom_range(0, 15)); while (b == a);
        align();
        pressed    = 16'h0;
        pressed[a] = 1'b1;
        pressed[b] = 1'b1;
        pulses     = 0;
        for (int n = 1; n <= 6 * Frame; n++) begin
            @(posedge clk);
            #1;
            if (n == 3 * Frame) pressed = 16'h0;
            if (key_valid) pulses++;
        end
        chk("multi.pulses", 32'(pulses), 32'd0);
        for (int t = 0; t < int'(MAX_TRIES); t++) begin
            do begin
                v = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)),
                     4'($urandom_range(0, 14)), 4'($urandom_range(0, 14))};
            end while (v == CODE);
            enter_code(v);
        end
        enter_code(CODE);

        // start falling clears the game; then explosion on the last digit
        pulse_reset();
        do v = 16'($urandom); while (v == CODE || v[15:12] == 4'hF || v[11:8] == 4'hF ||
                                     v[7:4] == 4'hF || v[3:0] == 4'hF);
        enter_code(v);
        press(4'h7, 1'b0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_entry.delete();
        m_tries = 0;
        check_status("start.fall");
        start = 1'b1;
        press(4'h1, 1'b0);
        press(4'h2, 1'b0);
        press(4'h3, 1'b0);
        press(4'h4, 1'b1);

        // Reset in the middle of a press, then a clean defuse
        pulse_reset();
        press(4'h1, 1'b0);
        align();
        pressed[2] = 1'b1;
        repeat (20) @(posedge clk);
        pulse_reset();
        enter_code(CODE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
